// File: rtl/cpu_pkg.sv
// Shared opcode map and parameter legality helpers for the CPU execute stage.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'h1,
        OP_MOV = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_AND = 4'h5,
        OP_OR  = 4'h6,
        OP_XOR = 4'h7,
        OP_SHL = 4'h8,
        OP_SHR = 4'h9,
        OP_CMP = 4'hA,
        OP_OUT = 4'hB,
        OP_JMP = 4'hC,
        OP_JZ  = 4'hD,
        OP_JC  = 4'hE,
        OP_JNZ = 4'hF
    } opcode_t;

    function automatic bit num_regs_legal(input int n);
        return (n == 2) || (n == 4);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational result and Z/C generation for every opcode; no state.
module cpu_alu
    import cpu_pkg::*;
(
    input  opcode_t     i_op,
    input  logic [3:0]  i_a,
    input  logic [3:0]  i_b,
    output logic [3:0]  o_res,
    output logic        o_z,
    output logic        o_c
);

    logic [4:0] w_wide;

    // Bit 4 of w_wide carries the C value for ops that touch flags.
    always_comb begin
        w_wide = {1'b0, i_a};
        case (i_op)
            OP_ADD:         w_wide = {1'b0, i_a} + {1'b0, i_b};
            OP_SUB, OP_CMP: w_wide = {1'b0, i_a} - {1'b0, i_b};
            OP_AND:         w_wide = {1'b0, i_a & i_b};
            OP_OR:          w_wide = {1'b0, i_a | i_b};
            OP_XOR:         w_wide = {1'b0, i_a ^ i_b};
            OP_SHL:         w_wide = {i_a, 1'b0};
            OP_SHR:         w_wide = {i_a[0], 1'b0, i_a[3:1]};
            OP_LDI, OP_MOV: w_wide = {1'b0, i_b};
            default:        w_wide = {1'b0, i_a};
        endcase
    end

    assign o_res = w_wide[3:0];
    assign o_c   = w_wide[4];
    assign o_z   = (w_wide[3:0] == 4'd0);

endmodule

// File: rtl/cpu_exec_stage.sv
// Single-cycle execute stage: register file, Z/C flags, output port and jump decision.
module cpu_exec_stage
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 4
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [3:0]  command,
    input  logic [3:0]  A,
    input  logic [3:0]  B,
    output logic        DoJump,
    output logic [3:0]  Out_data,
    output logic        Out_valid,
    output logic        Zero,
    output logic        Carry
);

    localparam int K = $clog2(NUM_REGS);

    generate
        if (!num_regs_legal(NUM_REGS)) begin : g_bad_num_regs
            $error("cpu_exec_stage: NUM_REGS must be 2 or 4");
        end
    endgenerate

    logic [3:0]   r_regs [NUM_REGS];
    logic         r_zero;
    logic         r_carry;
    logic [3:0]   r_out_data;
    logic         r_out_valid;

    opcode_t      w_op;
    logic [K-1:0] w_ia;
    logic [K-1:0] w_ib;
    logic [3:0]   w_opa;
    logic [3:0]   w_opb;
    logic [3:0]   w_res;
    logic         w_z;
    logic         w_c;
    logic         w_wr_reg;
    logic         w_wr_flags;
    logic         w_jump;
    logic [3-K:0] w_unused_a;

    assign w_op       = opcode_t'(command);
    assign w_ia       = A[K-1:0];
    assign w_ib       = B[K-1:0];
    assign w_unused_a = A[3:K];
    assign w_opa      = r_regs[w_ia];
    // LDI takes B as an immediate; everything else reads B as a register index.
    assign w_opb      = (w_op == OP_LDI) ? B : r_regs[w_ib];

    cpu_alu u_alu (
        .i_op  (w_op),
        .i_a   (w_opa),
        .i_b   (w_opb),
        .o_res (w_res),
        .o_z   (w_z),
        .o_c   (w_c)
    );

    assign w_wr_reg   = (w_op >= OP_LDI) && (w_op <= OP_SHR);
    assign w_wr_flags = (w_op >= OP_ADD) && (w_op <= OP_CMP);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 4'd0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_out_data  <= 4'd0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_wr_reg) r_regs[w_ia] <= w_res;
            if (w_wr_flags) begin
                r_zero  <= w_z;
                r_carry <= w_c;
            end
            r_out_valid <= (w_op == OP_OUT);
            if (w_op == OP_OUT) r_out_data <= w_opa;
        end
    end

    // Jumps look at the flags left by the previous instruction.
    always_comb begin
        w_jump = 1'b0;
        case (w_op)
            OP_JMP:  w_jump = 1'b1;
            OP_JZ:   w_jump = r_zero;
            OP_JC:   w_jump = r_carry;
            OP_JNZ:  w_jump = ~r_zero;
            default: w_jump = 1'b0;
        endcase
    end

    assign DoJump    = Reset_n & w_jump;
    assign Out_data  = r_out_data;
    assign Out_valid = r_out_valid;
    assign Zero      = r_zero;
    assign Carry     = r_carry;

endmodule

// File: tb/tb_cpu_exec_stage.sv
// Randomised and directed checks of cpu_exec_stage against an arithmetic reference model.
module tb_cpu_exec_stage;

    localparam int NR = 4;

    logic       Clock;
    logic       Reset_n;
    logic [3:0] command;
    logic [3:0] A;
    logic [3:0] B;
    logic       DoJump;
    logic [3:0] Out_data;
    logic       Out_valid;
    logic       Zero;
    logic       Carry;

    int n_cmp = 0;
    int n_err = 0;

    int m_r [NR];
    int m_z, m_c, m_od, m_ov;

    cpu_exec_stage #(.NUM_REGS(NR)) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .command   (command),
        .A         (A),
        .B         (B),
        .DoJump    (DoJump),
        .Out_data  (Out_data),
        .Out_valid (Out_valid),
        .Zero      (Zero),
        .Carry     (Carry)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_r[i] = 0;
        m_z = 0; m_c = 0; m_od = 0; m_ov = 0;
    endtask

    function automatic int m_jump(input int op);
        case (op)
            12:      return 1;
            13:      return m_z;
            14:      return m_c;
            15:      return 1 - m_z;
            default: return 0;
        endcase
    endfunction

    task automatic model_exec(input int op, input int a, input int b);
        int ia, ib, x, y, res;
        ia = a % NR; ib = b % NR;
        x = m_r[ia]; y = m_r[ib];
        m_ov = 0;
        case (op)
            1: m_r[ia] = b;
            2: m_r[ia] = y;
            3: begin res = x + y; m_c = (res > 15) ? 1 : 0; res = res % 16;
                     m_z = (res == 0) ? 1 : 0; m_r[ia] = res; end
            4, 10: begin res = x - y; m_c = (res < 0) ? 1 : 0; if (res < 0) res += 16;
                     m_z = (res == 0) ? 1 : 0; if (op == 4) m_r[ia] = res; end
            5, 6, 7: begin
                     res = (op == 5) ? (x & y) : (op == 6) ? (x | y) : (x ^ y);
                     m_c = 0; m_z = (res == 0) ? 1 : 0; m_r[ia] = res; end
            8: begin m_c = x / 8; res = (x * 2) % 16; m_z = (res == 0) ? 1 : 0; m_r[ia] = res; end
            9: begin m_c = x % 2; res = x / 2; m_z = (res == 0) ? 1 : 0; m_r[ia] = res; end
            11: begin m_od = x; m_ov = 1; end
            default: ;
        endcase
    endtask

    // Called at a negedge: drive, check the combinational jump, clock, check registered outputs.
    task automatic step(input int op, input int a, input int b);
        command = 4'(op); A = 4'(a); B = 4'(b);
        #1;
        chk("dojump", DoJump, 5'(m_jump(op)));
        @(posedge Clock);
        model_exec(op, a, b);
        @(negedge Clock);
        chk("zero", Zero, 5'(m_z));
        chk("carry", Carry, 5'(m_c));
        chk("out_valid", Out_valid, 5'(m_ov));
        chk("out_data", Out_data, 5'(m_od));
    endtask

    task automatic lit_jump(input string name, input int op, input logic exp);
        command = 4'(op);
        #1;
        chk(name, DoJump, {4'd0, exp});
    endtask

    initial begin
        Reset_n = 1'b1; command = 4'h0; A = 4'h0; B = 4'h0;
        model_reset();
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_zero", Zero, 5'd0);
        chk("rst_carry", Carry, 5'd0);
        chk("rst_out_valid", Out_valid, 5'd0);
        chk("rst_out_data", Out_data, 5'd0);
        command = 4'hC;
        #1 chk("rst_dojump", DoJump, 5'd0);
        command = 4'h0;
        repeat (2) @(posedge Clock);
        @(negedge Clock) Reset_n = 1'b1;

        // ADD overflow to zero, then JZ
        step(1, 0, 9); step(1, 1, 7); step(3, 0, 1);
        chk("add_z", Zero, 5'd1);
        chk("add_c", Carry, 5'd1);
        lit_jump("jz_taken", 13, 1'b1);
        step(13, 0, 0);

        // borrow, CMP, JC/JNZ
        step(1, 2, 3); step(1, 3, 5); step(4, 2, 3);
        chk("sub_c", Carry, 5'd1);
        chk("sub_z", Zero, 5'd0);
        step(11, 2, 0);
        chk("sub_r2", Out_data, 5'hE);
        step(10, 3, 3);
        chk("cmp_z", Zero, 5'd1);
        chk("cmp_c", Carry, 5'd0);
        step(11, 3, 0);
        chk("cmp_r3", Out_data, 5'd5);
        lit_jump("jc_not", 14, 1'b0);
        step(14, 0, 0);
        lit_jump("jnz_not", 15, 1'b0);
        step(15, 0, 0);

        // output port strobe
        step(1, 1, 10);
        step(11, 1, 0);
        chk("out1_v", Out_valid, 5'd1); chk("out1_d", Out_data, 5'hA);
        step(11, 0, 0);
        chk("out2_v", Out_valid, 5'd1); chk("out2_d", Out_data, 5'd0);
        step(0, 0, 0);
        chk("out3_v", Out_valid, 5'd0); chk("out3_d", Out_data, 5'd0);

        // shifts and same-register operands
        step(1, 0, 9); step(8, 0, 0);
        chk("shl_c", Carry, 5'd1);
        step(11, 0, 0); chk("shl_r0", Out_data, 5'd2);
        step(9, 0, 0);
        chk("shr_c", Carry, 5'd0);
        step(11, 0, 0); chk("shr_r0", Out_data, 5'd1);
        step(3, 0, 0);
        step(11, 0, 0); chk("add_self", Out_data, 5'd2);

        for (int i = 0; i < 600; i++)
            step(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));

        // mid-operation asynchronous reset
        step(1, 1, 15); step(11, 1, 0); step(3, 1, 1);
        command = 4'h3; A = 4'h1; B = 4'h1;
        #2 Reset_n = 1'b0;
        #1;
        chk("mid_rst_zero", Zero, 5'd0);
        chk("mid_rst_carry", Carry, 5'd0);
        chk("mid_rst_out_valid", Out_valid, 5'd0);
        chk("mid_rst_out_data", Out_data, 5'd0);
        command = 4'hC;
        #1 chk("mid_rst_dojump", DoJump, 5'd0);
        model_reset();
        @(posedge Clock);
        @(negedge Clock) Reset_n = 1'b1;
        step(11, 1, 0);
        chk("post_rst_r1", Out_data, 5'd0);
        step(1, 0, 4); step(11, 0, 0);
        chk("post_rst_out", Out_data, 5'd4);
        chk("post_rst_valid", Out_valid, 5'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
